div_radix2: RTL

DIV_RADIX2 -- requirements
Module: div_radix2

---
 rtl/div_radix2.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/div_radix2.sv
// Restoring radix-2 divider, 32/32 signed or unsigned, one quotient bit per clock.
// Ports: clk, rst, signed_div, opdata1, opdata2, start, annul in; result {rem,quot}, ready, stall out.
module div_radix2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        start,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready,
  output logic        stall
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DZERO = 2'b01,
    ON    = 2'b10,
    END   = 2'b11
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [5:0]  cnt;
  logic [63:0] acc;
  logic [31:0] dvs;
  logic        neg_q;
  logic        neg_r;

  logic        load;
  logic        step_en;
  logic        commit;
  logic        commit_zero;

  logic [31:0] abs1;
  logic [31:0] abs2;
  logic [64:0] shifted;
  logic        fits;
  logic [63:0] acc_step;
  logic [31:0] quot_raw;
  logic [31:0] rem_raw;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  // Two's complement negation of 32'h80000000 yields itself,
  // which read unsigned is the required 2^31 magnitude.
  always_comb begin
    abs1 = opdata1;
    abs2 = opdata2;
    if (signed_div && opdata1[31])
      abs1 = 32'd0 - opdata1;
    if (signed_div && opdata2[31])
      abs2 = 32'd0 - opdata2;
  end

  // acc = {partial remainder, dividend/quotient}.
  // The shifted value is 65 bits wide; bit 64 set means
  // the trial subtract cannot go negative.
  always_comb begin
    shifted  = {acc, 1'b0};
    fits     = shifted[64] || (shifted[63:32] >= dvs);
    acc_step = shifted[63:0];
    if (fits)
      acc_step = {shifted[63:32] - dvs,
                  shifted[31:1], 1'b1};
  end

  always_comb begin
    quot_raw = acc_step[31:0];
    rem_raw  = acc_step[63:32];
    quot_fix = quot_raw;
    rem_fix  = rem_raw;
    if (neg_q)
      quot_fix = 32'd0 - quot_raw;
    if (neg_r)
      rem_fix = 32'd0 - rem_raw;
  end

  always_comb begin
    state_n     = state;
    load        = 1'b0;
    step_en     = 1'b0;
    commit      = 1'b0;
    commit_zero = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !annul) begin
          if (opdata2 == 32'd0) begin
            state_n = DZERO;
          end else begin
            state_n = ON;
            load    = 1'b1;
          end
        end
      end
      ON: begin
        if (annul) begin
          state_n = IDLE;
        end else begin
          step_en = 1'b1;
          if (cnt == 6'd31) begin
            state_n = END;
            commit  = 1'b1;
          end
        end
      end
      DZERO: begin
        if (annul) begin
          state_n = IDLE;
        end else begin
          state_n     = END;
          commit_zero = 1'b1;
        end
      end
      END: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 6'd0;
      acc    <= 64'd0;
      dvs    <= 32'd0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= 64'd0;
    end else begin
      state <= state_n;
      if (load) begin
        acc   <= {32'd0, abs1};
        dvs   <= abs2;
        cnt   <= 6'd0;
        neg_q <= signed_div
                 && (opdata1[31] ^ opdata2[31]);
        neg_r <= signed_div && opdata1[31];
      end
      if (step_en) begin
        acc <= acc_step;
        cnt <= cnt + 6'd1;
      end
      if (commit)
        result <= {rem_fix, quot_fix};
      if (commit_zero)
        result <= 64'd0;
    end
  end

  assign ready = (state == END);
  assign stall = start & ~ready;

endmodule
